// File: rtl/relu_maxpool_col.sv
// ReLU followed by 2x2 stride-2 max-pooling over a stream of convolution columns.
// Row pairs pool within a column; column pairs pool across consecutive accepted columns.
module relu_maxpool_col #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ROWS   = 7,
    parameter int NUM_COLS   = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0]        col_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [(NUM_ROWS/2)*DATA_WIDTH-1:0]    out_data,
    output logic                                  out_last
);

    localparam int OUT_ROWS = NUM_ROWS / 2;
    localparam int OUT_COLS = NUM_COLS / 2;
    localparam int CW       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int OCW      = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam logic [CW-1:0]  LAST_COL = CW'(NUM_COLS - 1);
    localparam logic [OCW-1:0] LAST_OUT = OCW'(OUT_COLS - 1);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_cnt_q, col_cnt_d;
    logic [OCW-1:0]          out_cnt_q, out_cnt_d;
    logic [DATA_WIDTH-1:0]   hold_q [OUT_ROWS];
    logic [DATA_WIDTH-1:0]   hold_d [OUT_ROWS];
    logic [DATA_WIDTH-1:0]   r      [OUT_ROWS];
    logic                    out_valid_d;
    logic                    out_last_d;
    logic [OUT_ROWS*DATA_WIDTH-1:0] out_data_d;
    logic                    in_xfer;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? '0 : x;
    endfunction

    // Operands are already ReLU'd, so an unsigned compare is exact.
    function automatic logic [DATA_WIDTH-1:0] umax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // A stalled output blocks all input; otherwise one column per cycle flows through.
    assign in_ready = !(out_valid && !out_ready);
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        for (int i = 0; i < OUT_ROWS; i++) begin
            r[i] = umax(relu(col_in[(2*i)*DATA_WIDTH +: DATA_WIDTH]),
                        relu(col_in[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        out_cnt_d   = out_cnt_q;
        hold_d      = hold_q;
        out_valid_d = out_valid && !out_ready;
        out_data_d  = out_data;
        out_last_d  = out_last;
        if (in_xfer) begin
            col_cnt_d = (col_cnt_q == LAST_COL) ? '0 : col_cnt_q + 1'b1;
            case (state_q)
                EMPTY: begin
                    hold_d  = r;
                    // A trailing unpaired column of an odd-width map is dropped here.
                    state_d = (col_cnt_q == LAST_COL) ? EMPTY : HELD;
                end
                HELD: begin
                    for (int i = 0; i < OUT_ROWS; i++) begin
                        out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = umax(hold_q[i], r[i]);
                    end
                    out_valid_d = 1'b1;
                    out_last_d  = (out_cnt_q == LAST_OUT);
                    out_cnt_d   = (out_cnt_q == LAST_OUT) ? '0 : out_cnt_q + 1'b1;
                    state_d     = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EMPTY;
            col_cnt_q <= '0;
            out_cnt_q <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            // NOTE: the hold array is a few flops, not a RAM, so it is cleared on reset.
            for (int i = 0; i < OUT_ROWS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            out_cnt_q <= out_cnt_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            for (int i = 0; i < OUT_ROWS; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_col.sv
// Directed bench for relu_maxpool_col: reset, pooling, streaming, backpressure,
// extremes, asynchronous reset mid-pair and input gaps.
module tb_relu_maxpool_col;

    localparam int DW = 32;
    localparam int NR = 7;
    localparam int OR = 3;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [NR*DW-1:0]  col_in;
    logic              out_valid;
    logic              out_ready;
    logic [OR*DW-1:0]  out_data;
    logic              out_last;

    int asserts;
    int failures;

    relu_maxpool_col dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .col_in    (col_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NR*DW-1:0] mk_col(input logic [DW-1:0] v0, v1, v2, v3, v4, v5, v6);
        return {v6, v5, v4, v3, v2, v1, v0};
    endfunction

    function automatic logic [NR*DW-1:0] fill(input logic [DW-1:0] v);
        return {NR{v}};
    endfunction

    function automatic logic [OR*DW-1:0] mk_out(input logic [DW-1:0] a, b, c);
        return {c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        col_in    = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic send_col(input logic [NR*DW-1:0] c);
        int n;
        in_valid = 1'b1;
        col_in   = c;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        asserts++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        col_in    = '0;
        #12;
        asserts++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        asserts++;
        if (out_data !== '0) begin failures++; $display("FAIL reset_data: got %h required 0", out_data); end
        asserts++;
        if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b required 0", out_last); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        asserts++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [OR*DW-1:0] exp;
        do_reset();
        send_col(mk_col(5, -3, 10, 2, -7, -1, 99));
        asserts++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_half_valid: got %b required 0", out_valid); end
        send_col(mk_col(1, 8, -4, 12, -2, -9, 50));
        exp = mk_out(8, 12, 0);
        asserts++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b required 1", out_valid); end
        asserts++;
        if (out_data !== exp) begin failures++; $display("FAIL basic_data: got %h required %h", out_data, exp); end
        asserts++;
        if (out_last !== 1'b0) begin failures++; $display("FAIL basic_last: got %b required 0", out_last); end
        tick();
        asserts++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed: got %b required 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        logic [OR*DW-1:0] exp;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            col_in   = fill(c);
            asserts++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_col%0d: got %b required 1", c, in_ready); end
            tick();
            exp_v = (c % 2 == 1) && (c < 6);
            asserts++;
            if (out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid_col%0d: got %b required %b", c, out_valid, exp_v); end
            if (exp_v) begin
                exp = mk_out(c, c, c);
                asserts++;
                if (out_data !== exp) begin failures++; $display("FAIL b2b_data_col%0d: got %h required %h", c, out_data, exp); end
                asserts++;
                if (out_last !== (c == 5)) begin failures++; $display("FAIL b2b_last_col%0d: got %b required %b", c, out_last, c == 5); end
            end
        end
        col_in = fill(10);
        tick();
        asserts++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_frame2_col0: got valid %b required 0", out_valid); end
        col_in = fill(20);
        tick();
        in_valid = 1'b0;
        exp = mk_out(20, 20, 20);
        asserts++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            failures++; $display("FAIL b2b_frame2_data: got valid %b data %h required 1 %h", out_valid, out_data, exp);
        end
        asserts++;
        if (out_last !== 1'b0) begin failures++; $display("FAIL b2b_frame2_last: got %b required 0", out_last); end
    endtask

    task automatic test_backpressure();
        logic [OR*DW-1:0] exp;
        do_reset();
        out_ready = 1'b0;
        send_col(fill(1));
        send_col(fill(2));
        exp = mk_out(2, 2, 2);
        in_valid = 1'b1;
        col_in   = fill(7);
        for (int k = 0; k < 5; k++) begin
            asserts++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_c%0d: got %b required 0", k, in_ready); end
            asserts++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_c%0d: got %b required 1", k, out_valid); end
            asserts++;
            if (out_data !== exp) begin failures++; $display("FAIL bp_data_c%0d: got %h required %h", k, out_data, exp); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        asserts++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        tick();
        in_valid = 1'b0;
        asserts++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b required 0", out_valid); end
        send_col(fill(3));
        exp = mk_out(7, 7, 7);
        asserts++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            failures++; $display("FAIL bp_resume_data: got valid %b data %h required 1 %h", out_valid, out_data, exp);
        end
    endtask

    task automatic test_extremes();
        logic [OR*DW-1:0] exp;
        do_reset();
        send_col(fill(32'h8000_0000));
        send_col(fill(32'h8000_0000));
        exp = '0;
        asserts++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            failures++; $display("FAIL ext_negative: got valid %b data %h required 1 %h", out_valid, out_data, exp);
        end
        send_col(fill(32'h7FFF_FFFF));
        send_col(fill(32'h7FFF_FFFF));
        exp = mk_out(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        asserts++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            failures++; $display("FAIL ext_positive: got valid %b data %h required 1 %h", out_valid, out_data, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [OR*DW-1:0] exp;
        do_reset();
        out_ready = 1'b0;
        send_col(fill(1));
        send_col(fill(2));
        #2 rst = 1'b0;
        #1;
        asserts++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
            failures++; $display("FAIL arst_pending: got valid %b data %h last %b required 0 0 0", out_valid, out_data, out_last);
        end
        #2 rst = 1'b1;
        tick();
        out_ready = 1'b1;
        send_col(fill(100));
        #2 rst = 1'b0;
        #1;
        asserts++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid: got %b required 0", out_valid); end
        #2 rst = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            send_col(fill(2 + 4*p));
            send_col(fill(4 + 4*p));
            exp = mk_out(4 + 4*p, 4 + 4*p, 4 + 4*p);
            asserts++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                failures++; $display("FAIL arst_pair%0d_data: got valid %b data %h required 1 %h", p, out_valid, out_data, exp);
            end
            asserts++;
            if (out_last !== (p == 2)) begin failures++; $display("FAIL arst_pair%0d_last: got %b required %b", p, out_last, p == 2); end
        end
    endtask

    task automatic test_gaps();
        logic [OR*DW-1:0] exp;
        do_reset();
        send_col(mk_col(5, -3, 10, 2, -7, -1, 99));
        for (int k = 0; k < 3; k++) begin
            tick();
            asserts++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_idle%0d_valid: got %b required 0", k, out_valid); end
        end
        send_col(mk_col(1, 8, -4, 12, -2, -9, 50));
        exp = mk_out(8, 12, 0);
        asserts++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            failures++; $display("FAIL gap_data: got valid %b data %h required 1 %h", out_valid, out_data, exp);
        end
    endtask

    initial begin
        asserts  = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_extremes();
        test_async_reset();
        test_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
